window_scan_counter: RTL and testbench
======================================

WINDOW_SCAN_COUNTER -- requirements
Module: window_scan_counter

Interface
REQ-001 The block SHALL have parameter X_WIDTH, default 8, bit width of the outer (row) index and of x_end_i.
REQ-002 The block SHALL have parameter Y_WIDTH, default 8, bit width of the inner (column) index and of y_end_i.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 16, bit width of the linear address output.
REQ-004 The block SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port start_i, input, 1, which begins a scan when the block is idle.
REQ-007 The block SHALL have port clear_i, input, 1, a synchronous abort.
REQ-008 The block SHALL have port x_end_i, input, X_WIDTH, the last X index, sampled at start.
REQ-009 The block SHALL have port y_end_i, input, Y_WIDTH, the last Y index, sampled at start.
REQ-010 The block SHALL have port ready_i, input, 1, consumer accept.
REQ-011 The block SHALL have port X_o, output, X_WIDTH, current outer index.
REQ-012 The block SHALL have port Y_o, output, Y_WIDTH, current inner index.
REQ-013 The block SHALL have port addr_o, output, ADDR_WIDTH, linear address X*(y_end+1)+Y.
REQ-014 The block SHALL have port valid_o, output, 1, which is high when the current coordinate is offered.
REQ-015 The block SHALL have port last_o, output, 1, which is high when the current offered coordinate is the final one.
REQ-016 The block SHALL have port busy_o, output, 1, which is high whenever the block is not in IDLE.
REQ-017 The block SHALL have port done_o, output, 1, a one-cycle pulse at normal scan completion.

Function
REQ-018 The block SHALL implement a state machine with exactly the states IDLE, RUN and DONE.
REQ-019 In IDLE, when start_i=1 (and clear_i=0), the block SHALL latch x_end_i and y_end_i, load X_o=X0, Y_o=Y0 and addr_o=A0, and move to RUN on the next edge; valid_o SHALL first be high in that next cycle.
REQ-020 With the feature of REQ-032 disabled, X0=0, Y0=0 and A0=0.
REQ-021 In RUN, valid_o SHALL be 1; a beat SHALL be accepted only when valid_o=1 and ready_i=1, and the outputs SHALL hold their values while ready_i=0.
REQ-022 On an accepted beat with Y_o below the latched Y limit, the block SHALL increment Y_o and increment addr_o by 1.
REQ-023 On an accepted beat with Y_o equal to the Y limit, the block SHALL set Y_o to Y0, increment X_o and increment addr_o by the row step (1, or 3 per REQ-032).
REQ-024 last_o SHALL equal valid_o AND (X_o = X limit) AND (Y_o = Y limit), evaluated combinationally.
REQ-025 On an accepted beat with last_o=1, the block SHALL go to DONE without further coordinate change.
REQ-026 In DONE, done_o SHALL be 1 for exactly one cycle, and the block SHALL then return to IDLE.
REQ-027 start_i SHALL be ignored in RUN and DONE.
REQ-028 clear_i=1 SHALL take priority over start_i and ready_i in every state, forcing IDLE with X_o=0, Y_o=0 and addr_o=0, and done_o SHALL NOT pulse.
REQ-029 With limits 0/0, the block SHALL deliver exactly one beat, (0,0) with last_o=1.
REQ-030 addr_o SHALL wrap modulo 2^ADDR_WIDTH with no error indication.

Reset
REQ-031 While rst_i=1, asynchronously: state=IDLE, X_o=0, Y_o=0, addr_o=0, latched limits=0, and valid_o, last_o, busy_o and done_o all 0; a reset mid-scan SHALL abandon the scan with no done_o pulse.

Configuration
REQ-032 The macro WSC_BORDER_SKIP_EN, when defined, SHALL make the scan cover only interior pixels: X0=1, Y0=1, A0=y_end+2, X limit=x_end-1, Y limit=y_end-1, row step 3.
REQ-033 With WSC_BORDER_SKIP_EN defined and x_end_i<2 or y_end_i<2 at start, the block SHALL go IDLE->DONE directly, pulse done_o and produce zero beats.
REQ-034 Without WSC_BORDER_SKIP_EN, the block SHALL scan the full grid and REQ-033 logic SHALL be absent.

Verification
REQ-035 Limits 2/3, ready_i held high, pulse start -> 12 consecutive beats (0,0),(0,1)..(2,3), addr 0..11, last_o on (2,3), done_o one cycle later.
REQ-036 Limits 1/1, ready_i toggling 1,0,1,0 -> 4 beats, with X_o, Y_o and addr_o stable during each ready_i=0 cycle, and no beat dropped or duplicated.
REQ-037 Limits 3/3, clear_i asserted at beat (1,2) alongside start_i=1 -> IDLE next cycle, outputs 0, no done_o, start ignored.
REQ-038 Limits 3/3, rst_i asserted mid-row -> all outputs 0 immediately (asynchronously, before the next clock edge), busy_o=0.
REQ-039 WSC_BORDER_SKIP_EN defined, limits 3/3 -> beats (1,1),(1,2),(2,1),(2,2) with addr 5,6,9,10; limits 1/3 -> done_o with zero beats.
REQ-040 Limits 0/0 -> a single beat with last_o=1, and done_o is 1 for exactly one cycle.

Source files
------------

// File: rtl/window_scan_counter_if.sv
// -----------------------------------------------------------------------------
// window_scan_counter_if
// Purpose : bundles the control, limit and handshake signals of
//           window_scan_counter so that a consumer and the counter connect
//           through a single port.
// Signals : start_i, clear_i   - scan start / synchronous abort (master -> slave)
//           x_end_i, y_end_i   - last X / Y index, sampled at start
//           ready_i            - consumer accept
//           X_o, Y_o, addr_o   - current coordinate and linear address
//           valid_o, last_o    - beat offered / final beat
//           busy_o, done_o     - not idle / one-cycle completion pulse
// Modports: master (consumer side), slave (window_scan_counter side)
// -----------------------------------------------------------------------------
interface window_scan_counter_if #(
   parameter int X_WIDTH    = 8,
   parameter int Y_WIDTH    = 8,
   parameter int ADDR_WIDTH = 16
);
   logic                  start_i;
   logic                  clear_i;
   logic [X_WIDTH-1:0]    x_end_i;
   logic [Y_WIDTH-1:0]    y_end_i;
   logic                  ready_i;
   logic [X_WIDTH-1:0]    X_o;
   logic [Y_WIDTH-1:0]    Y_o;
   logic [ADDR_WIDTH-1:0] addr_o;
   logic                  valid_o;
   logic                  last_o;
   logic                  busy_o;
   logic                  done_o;

   modport master (
      output start_i, clear_i, x_end_i, y_end_i, ready_i,
      input  X_o, Y_o, addr_o, valid_o, last_o, busy_o, done_o
   );

   modport slave (
      input  start_i, clear_i, x_end_i, y_end_i, ready_i,
      output X_o, Y_o, addr_o, valid_o, last_o, busy_o, done_o
   );
endinterface

// File: rtl/window_scan_counter.sv
// -----------------------------------------------------------------------------
// window_scan_counter
// Purpose : raster scan generator. After start it offers every (X, Y)
//           coordinate of a grid, Y innermost, together with the linear
//           address X*(y_end+1)+Y, one beat per valid/ready handshake.
//           A one-cycle done_o pulse marks normal completion.
// Ports   : clk_i  - clock, rising edge
//           rst_i  - asynchronous active-high reset
//           bus    - window_scan_counter_if.slave (controls, limits,
//                    coordinate outputs and handshake)
// Config  : define WSC_BORDER_SKIP_EN to scan only interior pixels
//           (start at (1,1), stop one short of each limit, row step 3);
//           grids without an interior then finish with zero beats.
// -----------------------------------------------------------------------------
module window_scan_counter #(
   parameter int X_WIDTH    = 8,
   parameter int Y_WIDTH    = 8,
   parameter int ADDR_WIDTH = 16
) (
   input logic                  clk_i,
   input logic                  rst_i,
   window_scan_counter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

`ifdef WSC_BORDER_SKIP_EN
   localparam logic [X_WIDTH-1:0]    X0       = X_WIDTH'(1);
   localparam logic [Y_WIDTH-1:0]    Y0       = Y_WIDTH'(1);
   // Wrapping from the last interior column to the first interior column of
   // the next row skips the right border pixel and the left border pixel.
   localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(3);
`else
   localparam logic [X_WIDTH-1:0]    X0       = '0;
   localparam logic [Y_WIDTH-1:0]    Y0       = '0;
   localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(1);
`endif

   state_t                state_reg, state_next;
   logic [X_WIDTH-1:0]    x_reg;
   logic [Y_WIDTH-1:0]    y_reg;
   logic [ADDR_WIDTH-1:0] addr_reg;
   logic [X_WIDTH-1:0]    x_lim_reg;
   logic [Y_WIDTH-1:0]    y_lim_reg;

   logic                  accept;
   logic                  at_last;
   logic                  no_beats;
   logic [X_WIDTH-1:0]    x_lim_load;
   logic [Y_WIDTH-1:0]    y_lim_load;
   logic [ADDR_WIDTH-1:0] addr_load;

   assign accept  = (state_reg == RUN) && bus.ready_i;
   assign at_last = (x_reg == x_lim_reg) && (y_reg == y_lim_reg);

`ifdef WSC_BORDER_SKIP_EN
   // Fewer than three pixels along either axis leaves no interior; the
   // limit values loaded in that case are never used.
   assign no_beats   = (bus.x_end_i < X_WIDTH'(2)) || (bus.y_end_i < Y_WIDTH'(2));
   assign x_lim_load = bus.x_end_i - X_WIDTH'(1);
   assign y_lim_load = bus.y_end_i - Y_WIDTH'(1);
   assign addr_load  = ADDR_WIDTH'(bus.y_end_i) + ADDR_WIDTH'(2);
`else
   assign no_beats   = 1'b0;
   assign x_lim_load = bus.x_end_i;
   assign y_lim_load = bus.y_end_i;
   assign addr_load  = '0;
`endif

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic; clear_i overrides everything
   always_comb begin
      state_next = state_reg;
      if (bus.clear_i) begin
         state_next = IDLE;
      end else begin
         unique case (state_reg)
            IDLE:    if (bus.start_i) state_next = no_beats ? DONE : RUN;
            RUN:     if (accept && at_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // Output logic (Moore, except last_o which also needs the coordinate)
   always_comb begin
      bus.valid_o = (state_reg == RUN);
      bus.last_o  = (state_reg == RUN) && at_last;
      bus.busy_o  = (state_reg != IDLE);
      bus.done_o  = (state_reg == DONE);
   end

   // Coordinate / address counters and latched limits
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         x_reg     <= '0;
         y_reg     <= '0;
         addr_reg  <= '0;
         x_lim_reg <= '0;
         y_lim_reg <= '0;
      end else if (bus.clear_i) begin
         x_reg    <= '0;
         y_reg    <= '0;
         addr_reg <= '0;
      end else if (state_reg == IDLE && bus.start_i) begin
         x_lim_reg <= x_lim_load;
         y_lim_reg <= y_lim_load;
         x_reg     <= X0;
         y_reg     <= Y0;
         addr_reg  <= addr_load;
      end else if (accept && !at_last) begin
         if (y_reg == y_lim_reg) begin
            y_reg    <= Y0;
            x_reg    <= x_reg + X_WIDTH'(1);
            addr_reg <= addr_reg + ROW_STEP;
         end else begin
            y_reg    <= y_reg + Y_WIDTH'(1);
            addr_reg <= addr_reg + ADDR_WIDTH'(1);
         end
      end
   end

   assign bus.X_o    = x_reg;
   assign bus.Y_o    = y_reg;
   assign bus.addr_o = addr_reg;

endmodule

// File: tb/tb_window_scan_counter.sv
// -----------------------------------------------------------------------------
// tb_window_scan_counter
// Purpose : self-checking bench for window_scan_counter. Each scan builds the
//           expected beat list from nested loops over the grid, then drives
//           ready_i (held, toggling or random) and compares every accepted
//           beat, plus hold, abort and reset behaviour.
// Ports   : none (top-level bench)
// Config  : honours WSC_BORDER_SKIP_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_window_scan_counter;
   localparam int XW = 4;
   localparam int YW = 4;
   localparam int AW = 5;   // small address so large grids exercise wrap-around

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   window_scan_counter_if #(.X_WIDTH(XW), .Y_WIDTH(YW), .ADDR_WIDTH(AW)) bus ();

   window_scan_counter #(.X_WIDTH(XW), .Y_WIDTH(YW), .ADDR_WIDTH(AW)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      int x;
      int y;
      int a;
   } beat_t;

   beat_t exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected beats straight from the grid definition
   function automatic void build_expected(input int xe, input int ye);
      int x_lo, x_hi, y_lo, y_hi;
      beat_t b;
      exp_q.delete();
`ifdef WSC_BORDER_SKIP_EN
      if (xe < 2 || ye < 2) return;
      x_lo = 1; x_hi = xe - 1; y_lo = 1; y_hi = ye - 1;
`else
      x_lo = 0; x_hi = xe; y_lo = 0; y_hi = ye;
`endif
      for (int x = x_lo; x <= x_hi; x++) begin
         for (int y = y_lo; y <= y_hi; y++) begin
            b.x = x;
            b.y = y;
            b.a = (x * (ye + 1) + y) % (1 << AW);
            exp_q.push_back(b);
         end
      end
   endfunction

   // mode 0: ready held high, 1: ready 1,0,1,0..., 2: random ready
   task automatic run_scan(input int xe, input int ye, input int mode, input string name);
      bit    prev_hold;
      bit    done_seen;
      bit    rdy;
      int    px, py, pa;
      beat_t b;
      build_expected(xe, ye);
      prev_hold = 0;
      done_seen = 0;
      px = 0; py = 0; pa = 0;
      @(negedge clk);
      bus.x_end_i = XW'(xe);
      bus.y_end_i = YW'(ye);
      bus.start_i = 1'b1;
      bus.ready_i = 1'b0;
      #1;
      check({name, " idle_before_start"}, 32'(bus.busy_o), 0);
      @(negedge clk);
      bus.start_i = 1'b0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         if (cyc > 0) @(negedge clk);
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 2 == 0);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         bus.ready_i = rdy;
         #1;
         if (cyc == 0)
            check({name, " first_valid"}, 32'(bus.valid_o), 32'(exp_q.size() != 0));
         if (prev_hold && bus.valid_o) begin
            check({name, " hold_X"}, 32'(bus.X_o), 32'(px));
            check({name, " hold_Y"}, 32'(bus.Y_o), 32'(py));
            check({name, " hold_addr"}, 32'(bus.addr_o), 32'(pa));
         end
         prev_hold = bus.valid_o && !rdy;
         px = int'(bus.X_o); py = int'(bus.Y_o); pa = int'(bus.addr_o);
         if (bus.valid_o) begin
            check({name, " busy_in_run"}, 32'(bus.busy_o), 1);
            if (rdy) begin
               if (exp_q.size() == 0) begin
                  check({name, " extra_beat"}, 1, 0);
               end else begin
                  b = exp_q.pop_front();
                  $display("%s beat X=%0d Y=%0d addr=%0d last=%0b", name,
                           bus.X_o, bus.Y_o, bus.addr_o, bus.last_o);
                  check({name, " X"}, 32'(bus.X_o), 32'(b.x));
                  check({name, " Y"}, 32'(bus.Y_o), 32'(b.y));
                  check({name, " addr"}, 32'(bus.addr_o), 32'(b.a));
                  check({name, " last"}, 32'(bus.last_o), 32'(exp_q.size() == 0));
               end
            end else begin
               check({name, " last_consistent"}, 32'(bus.last_o), 32'(exp_q.size() == 1));
            end
         end
         if (bus.done_o) begin
            done_seen = 1;
            check({name, " beats_left_at_done"}, 32'(exp_q.size()), 0);
            check({name, " valid_at_done"}, 32'(bus.valid_o), 0);
            check({name, " busy_at_done"}, 32'(bus.busy_o), 1);
            break;
         end
      end
      check({name, " done_seen"}, 32'(done_seen), 1);
      @(negedge clk);
      #1;
      check({name, " done_one_cycle"}, 32'(bus.done_o), 0);
      check({name, " idle_after_done"}, 32'(bus.busy_o), 0);
      bus.ready_i = 1'b0;
   endtask

   // Start a 3/3 scan and advance (ready high) until the given coordinate is
   // offered; leaves the bench #1 after a falling edge.
   task automatic advance_to(input int tx, input int ty, input string name);
      bit found;
      found = 0;
      @(negedge clk);
      bus.x_end_i = XW'(3);
      bus.y_end_i = YW'(3);
      bus.start_i = 1'b1;
      bus.ready_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      #1;
      for (int i = 0; i < 100; i++) begin
         if (bus.valid_o && bus.X_o == XW'(tx) && bus.Y_o == YW'(ty)) begin
            found = 1;
            break;
         end
         @(negedge clk);
         #1;
      end
      check({name, " reached_target"}, 32'(found), 1);
   endtask

   initial begin
      rst         = 1'b1;
      bus.start_i = 1'b0;
      bus.clear_i = 1'b0;
      bus.ready_i = 1'b0;
      bus.x_end_i = '0;
      bus.y_end_i = '0;
      #2;
      check("reset valid", 32'(bus.valid_o), 0);
      check("reset busy", 32'(bus.busy_o), 0);
      check("reset done", 32'(bus.done_o), 0);
      check("reset last", 32'(bus.last_o), 0);
      check("reset X", 32'(bus.X_o), 0);
      check("reset Y", 32'(bus.Y_o), 0);
      check("reset addr", 32'(bus.addr_o), 0);
      @(negedge clk);
      rst = 1'b0;

      run_scan(2, 3, 0, "scan_2x3");
      run_scan(1, 1, 1, "scan_1x1_toggle");
      run_scan(0, 0, 0, "scan_0x0");
      run_scan(3, 3, 0, "scan_3x3");
      run_scan(1, 3, 0, "scan_1x3");
      run_scan(7, 7, 2, "scan_7x7_wrap");

      // Abort with clear_i, start_i asserted in the same cycle
      advance_to(1, 2, "clear");
      bus.clear_i = 1'b1;
      bus.start_i = 1'b1;
      @(negedge clk);
      #1;
      $display("clear applied busy=%0b X=%0d Y=%0d addr=%0d", bus.busy_o, bus.X_o, bus.Y_o, bus.addr_o);
      check("clear busy", 32'(bus.busy_o), 0);
      check("clear valid", 32'(bus.valid_o), 0);
      check("clear done", 32'(bus.done_o), 0);
      check("clear X", 32'(bus.X_o), 0);
      check("clear Y", 32'(bus.Y_o), 0);
      check("clear addr", 32'(bus.addr_o), 0);
      bus.clear_i = 1'b0;
      bus.start_i = 1'b0;
      @(negedge clk);
      #1;
      check("clear stays_idle", 32'(bus.busy_o), 0);
      check("clear no_done", 32'(bus.done_o), 0);

      // Asynchronous reset mid-row
      advance_to(1, 1, "reset");
      rst = 1'b1;
      #1;
      $display("reset applied busy=%0b X=%0d Y=%0d addr=%0d", bus.busy_o, bus.X_o, bus.Y_o, bus.addr_o);
      check("midreset busy", 32'(bus.busy_o), 0);
      check("midreset valid", 32'(bus.valid_o), 0);
      check("midreset last", 32'(bus.last_o), 0);
      check("midreset done", 32'(bus.done_o), 0);
      check("midreset X", 32'(bus.X_o), 0);
      check("midreset Y", 32'(bus.Y_o), 0);
      check("midreset addr", 32'(bus.addr_o), 0);
      @(negedge clk);
      rst = 1'b0;
      bus.ready_i = 1'b0;
      @(negedge clk);
      #1;
      check("after_reset no_done", 32'(bus.done_o), 0);
      check("after_reset idle", 32'(bus.busy_o), 0);

      // Random limits and random back-pressure
      for (int n = 0; n < 8; n++) begin
         run_scan(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 2, $sformatf("rand%0d", n));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
